// File: rtl/spread_frame_sequencer.sv
// spread_frame_sequencer: builds a bit-serial frame from a byte stream and feeds the
// spectrum spreader one bit at a time through its valid/ready bit handshake.
// Frame, MSB first: preamble, sync byte, length byte, payload bytes, optional CRC-8.
// Optional feature macro: SPREAD_CRC_EN appends a CRC-8 (poly 0x07, init 0x00) computed
// over the length byte and the payload.
module spread_frame_sequencer #(
    parameter int unsigned PREAMBLE_BITS    = 16,
    parameter logic [31:0] PREAMBLE_PATTERN = 32'h0000AAAA,
    parameter logic [7:0]  SYNC_WORD        = 8'hD5,
    parameter int unsigned LEN_W            = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_bit,
    output logic             o_bit_valid,
    input  logic             i_bit_ready,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CRC
    } state_t;

    // Preamble field left-aligned so its first bit is always bit 31.
    localparam logic [31:0] PRE_ALIGNED = PREAMBLE_PATTERN << (32 - PREAMBLE_BITS);
    localparam logic [4:0]  PRE_LAST    = 5'(PREAMBLE_BITS - 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] fetched;   // payload bytes accepted from the source
    logic [LEN_W-1:0] sent;      // payload bytes loaded into the shift register
    logic [4:0]       bit_cnt;
    logic [7:0]       hold_reg;
    logic             hold_full;
    logic [7:0]       shift_reg;

    logic             bit_xfer;
    logic             byte_xfer;
    logic             src_avail;
    logic [7:0]       src_byte;
    logic             len_end;
    logic             pay_last_bit;
    logic             pay_final;
    logic             need_byte;
    logic             load_now;

    assign bit_xfer     = o_bit_valid & i_bit_ready;
    assign o_byte_ready = ((state == S_SYNC) || (state == S_LEN) || (state == S_PAY))
                          && !hold_full && (fetched < len_q);
    assign byte_xfer    = i_byte_valid & o_byte_ready;

    // A byte can be loaded from the holding register, or straight from the source
    // when it arrives in the very cycle it is needed (underrun recovery).
    assign src_avail    = hold_full | byte_xfer;
    assign src_byte     = hold_full ? hold_reg : i_byte;

    assign len_end      = (state == S_LEN) && bit_xfer && (bit_cnt == 5'd7);
    assign pay_last_bit = (state == S_PAY) && bit_xfer && (bit_cnt == 5'd7);
    assign pay_final    = pay_last_bit && (sent == len_q);
    assign need_byte    = len_end || (pay_last_bit && !pay_final)
                          || ((state == S_PAY) && !o_bit_valid);
    assign load_now     = need_byte && src_avail;

`ifdef SPREAD_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_upd;

    // MSB-first CRC-8 step for the bit currently on o_bit.
    assign crc_upd = {crc[6:0], 1'b0} ^ ((crc[7] ^ o_bit) ? 8'h07 : 8'h00);
`endif

    // Holding register and fetch counter: fill on an accepted byte unless it is consumed directly.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            fetched   <= '0;
        end else if (state == S_IDLE) begin
            hold_full <= 1'b0;
            fetched   <= '0;
        end else begin
            if (byte_xfer) begin
                fetched <= fetched + LEN_W'(1);
            end
            if (load_now) begin
                hold_full <= 1'b0;
            end else if (byte_xfer) begin
                hold_reg  <= i_byte;
                hold_full <= 1'b1;
            end
        end
    end

    // Frame FSM with registered bit, valid, busy, done and err outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register regardless of statement order;
    // the payload-load block after the case statement relies on last-assignment-wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            len_q       <= '0;
            sent        <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
`ifdef SPREAD_CRC_EN
            crc         <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            state       <= S_PRE;
                            len_q       <= i_len;
                            sent        <= '0;
                            bit_cnt     <= '0;
                            o_bit       <= PRE_ALIGNED[31];
                            o_bit_valid <= 1'b1;
                            o_busy      <= 1'b1;
`ifdef SPREAD_CRC_EN
                            crc         <= '0;
`endif
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end

                S_PRE: begin
                    if (bit_xfer) begin
                        if (bit_cnt == PRE_LAST) begin
                            state   <= S_SYNC;
                            bit_cnt <= '0;
                            o_bit   <= SYNC_WORD[7];
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            o_bit   <= PRE_ALIGNED[5'd30 - bit_cnt];
                        end
                    end
                end

                S_SYNC: begin
                    if (bit_xfer) begin
                        if (bit_cnt == 5'd7) begin
                            state   <= S_LEN;
                            bit_cnt <= '0;
                            o_bit   <= len_q[7];
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            o_bit   <= SYNC_WORD[3'd6 - bit_cnt[2:0]];
                        end
                    end
                end

                S_LEN: begin
                    if (bit_xfer) begin
                        if (bit_cnt == 5'd7) begin
                            state   <= S_PAY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            o_bit   <= len_q[3'd6 - bit_cnt[2:0]];
                        end
                    end
                end

                S_PAY: begin
                    if (bit_xfer) begin
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (pay_final) begin
`ifdef SPREAD_CRC_EN
                                state       <= S_CRC;
                                o_bit       <= crc_upd[7];
`else
                                state       <= S_IDLE;
                                o_bit       <= 1'b0;
                                o_bit_valid <= 1'b0;
                                o_busy      <= 1'b0;
                                o_done      <= 1'b1;
`endif
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 5'd1;
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            o_bit     <= shift_reg[6];
                        end
                    end
                end

`ifdef SPREAD_CRC_EN
                S_CRC: begin
                    if (bit_xfer) begin
                        if (bit_cnt == 5'd7) begin
                            state       <= S_IDLE;
                            bit_cnt     <= '0;
                            o_bit       <= 1'b0;
                            o_bit_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            o_bit   <= crc[3'd6 - bit_cnt[2:0]];
                        end
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Payload byte boundary: present the next byte's MSB, or idle on underrun.
            if (load_now) begin
                shift_reg   <= src_byte;
                o_bit       <= src_byte[7];
                o_bit_valid <= 1'b1;
                sent        <= sent + LEN_W'(1);
            end else if (need_byte) begin
                o_bit_valid <= 1'b0;
            end

`ifdef SPREAD_CRC_EN
            if (bit_xfer && ((state == S_LEN) || (state == S_PAY))) begin
                crc <= crc_upd;
            end
`endif
        end
    end

endmodule
